// File: rtl/uart_rx_if.sv
// Consumer-side handshake for uart_rx: holding register, valid/ack pair and sticky error flags.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       overrun;
  logic       frame_err;
  logic       err_clr;

  modport master (
    output rx_data,
    output rx_valid,
    output overrun,
    output frame_err,
    input  rx_ack,
    input  err_clr
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  overrun,
    input  frame_err,
    output rx_ack,
    output err_clr
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling; rx_valid rises 3+HALF+9*DIV cycles after the start edge.
// Single holding register: a byte arriving while full and unacked is dropped and sets overrun.
module uart_rx #(
  parameter int CLKSPEED = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic     clk,
  input  logic     reset_b,
  input  logic     rxd,
  uart_rx_if.master rx_if
);

  localparam int DIV  = CLKSPEED / BAUD;
  localparam int HALF = DIV / 2;
  localparam int TW   = $clog2(DIV);
  localparam logic [TW-1:0] DIV_M1  = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          sync1_q;
  logic          rs_q;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;

  logic stop_tick;
  logic deliver;
  logic fe_set;

  assign stop_tick = (state_q == STOP) && (timer_q == DIV_M1);
  assign deliver   = stop_tick && rs_q;
  assign fe_set    = stop_tick && !rs_q;

  // Flops reset high so a line held low at release still reads as a falling edge.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync1_q <= 1'b1;
      rs_q    <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rs_q    <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (!rs_q) state_q <= START;
        end
        START: begin
          if (timer_q == HALF_M1) begin
            timer_q <= '0;
            idx_q   <= '0;
            state_q <= rs_q ? IDLE : DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DATA: begin
          if (timer_q == DIV_M1) begin
            timer_q         <= '0;
            shift_q[idx_q]  <= rs_q;
            idx_q           <= idx_q + 1'b1;
            if (idx_q == 3'd7) state_q <= STOP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        STOP: begin
          if (timer_q == DIV_M1) begin
            timer_q <= '0;
            state_q <= rs_q ? IDLE : WAIT_HIGH;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A break holds the line low; stay here so it raises one frame error only.
          if (rs_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    if (deliver) begin
      if (!rx_valid_q || rx_if.rx_ack) rx_data_d = shift_q;
      rx_valid_d = 1'b1;
    end else if (rx_if.rx_ack) begin
      rx_valid_d = 1'b0;
    end
    overrun_d   = (deliver && rx_valid_q && !rx_if.rx_ack) || (overrun_q && !rx_if.err_clr);
    frame_err_d = fe_set || (frame_err_q && !rx_if.err_clr);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.frame_err = frame_err_q;

endmodule
